// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver and its FIFOs.
package uart_pkg;

  localparam int OVS = 16;
  localparam int MID = 7;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  function automatic logic [3:0] clamp_dbits(input logic [3:0] d);
    if (d < 4'd5) return 4'd5;
    else if (d > 4'd9) return 4'd9;
    else return d;
  endfunction

  function automatic parity_e decode_parity(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO; empty head reads as zero, level saturates at depth.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  // Handshake: wr/rd are one-cycle strobes; wr is dropped when full, rd ignored when empty.
  assign empty = (level == '0);
  assign full  = (level == {1'b1, {AW{1'b0}}});
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Frame-configurable UART transceiver: baud generator, TX and RX FSMs, one FIFO per direction.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int MDW = 9,
  parameter int FAW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [15:0]    prescale,
  input  logic [3:0]     cfg_dbits,
  input  logic [1:0]     cfg_parity,
  input  logic           cfg_stop2,
  input  logic           tx_en,
  input  logic           rx_en,
  input  logic           wr,
  input  logic [MDW-1:0] wdata,
  output logic           tx_empty,
  output logic           tx_full,
  output logic [FAW:0]   tx_level,
  output logic           tx_busy,
  input  logic           rd,
  output logic [MDW-1:0] rdata,
  output logic           rx_perr,
  output logic           rx_ferr,
  output logic           rx_empty,
  output logic           rx_full,
  output logic [FAW:0]   rx_level,
  output logic           rx_ovr,
  input  logic           ovr_clr,
  output logic           rx_break,
  input  logic           RX,
  output logic           TX
);

  logic [15:0] baud_cnt;
  logic        tick;

  assign tick = en && (baud_cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  baud_cnt <= '0;
    else if (en) baud_cnt <= (baud_cnt == prescale) ? '0 : baud_cnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  tx_state_e      tx_state;
  logic [3:0]     tx_tcnt, tx_bcnt, tx_dbits, cfg_dbits_c;
  parity_e        tx_par_mode, cfg_par_c;
  logic           tx_stop2, tx_par_bit, tx_pop, tx_bit_end;
  logic [MDW-1:0] tx_shift, tx_head, tx_mask, tx_word;

  assign cfg_dbits_c = clamp_dbits(cfg_dbits);
  assign cfg_par_c   = decode_parity(cfg_parity);

  always_comb begin
    tx_mask = '0;
    for (int i = 0; i < MDW; i++) tx_mask[i] = (i < int'(cfg_dbits_c));
  end

  assign tx_word    = tx_head & tx_mask;
  assign tx_pop     = (tx_state == TX_IDLE) && tx_en && !tx_empty;
  assign tx_bit_end = tick && (tx_tcnt == 4'(OVS - 1));
  assign tx_busy    = (tx_state != TX_IDLE);

  uart_fifo #(.DW(MDW), .AW(FAW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wdata), .rd(tx_pop),
    .rdata(tx_head), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_tcnt     <= '0;
      tx_bcnt     <= '0;
      tx_dbits    <= 4'd8;
      tx_par_mode <= PAR_NONE;
      tx_stop2    <= 1'b0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      TX          <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_state    <= TX_START;
          tx_tcnt     <= '0;
          tx_dbits    <= cfg_dbits_c;
          tx_par_mode <= cfg_par_c;
          tx_stop2    <= cfg_stop2;
          tx_shift    <= tx_word;
          tx_par_bit  <= (^tx_word) ^ (cfg_par_c == PAR_ODD);
        end
        default: if (tick) begin
          tx_tcnt <= tx_tcnt + 1'b1;
          if (tx_bit_end) begin
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx_bcnt  <= '0;
              end
              TX_DATA: begin
                tx_shift <= tx_shift >> 1;
                if (tx_bcnt == tx_dbits - 1'b1)
                  tx_state <= (tx_par_mode == PAR_NONE) ? TX_STOP1 : TX_PARITY;
                else
                  tx_bcnt <= tx_bcnt + 1'b1;
              end
              TX_PARITY: tx_state <= TX_STOP1;
              TX_STOP1:  tx_state <= tx_stop2 ? TX_STOP2 : TX_IDLE;
              default:   tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
      // Line is registered from the current state, so it lags the FSM by one cycle.
      case (tx_state)
        TX_START:  TX <= 1'b0;
        TX_DATA:   TX <= tx_shift[0];
        TX_PARITY: TX <= tx_par_bit;
        default:   TX <= 1'b1;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_e      rx_state;
  logic           rx_s1, rx_s2;
  logic [3:0]     rx_tcnt, rx_bcnt, rx_dbits;
  parity_e        rx_par_mode;
  logic [MDW-1:0] rx_word;
  logic           rx_par_acc, rx_all_zero, rx_perr_q;
  logic           rx_samp, rx_push, rx_brk_det;
  logic [MDW+1:0] rx_head;

  assign rx_samp    = tick && (rx_tcnt == 4'(OVS - 1));
  assign rx_push    = (rx_state == RX_STOP) && rx_samp;
  assign rx_brk_det = rx_push && rx_all_zero && !rx_s2;

  uart_fifo #(.DW(MDW + 2), .AW(FAW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(rx_push), .wdata({rx_word, rx_perr_q, ~rx_s2}),
    .rd(rd), .rdata(rx_head), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );

  assign {rdata, rx_perr, rx_ferr} = rx_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_tcnt     <= '0;
      rx_bcnt     <= '0;
      rx_dbits    <= 4'd8;
      rx_par_mode <= PAR_NONE;
      rx_word     <= '0;
      rx_par_acc  <= 1'b0;
      rx_all_zero <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_break    <= 1'b0;
      rx_ovr      <= 1'b0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_break <= rx_brk_det;
      if (rx_push && rx_full) rx_ovr <= 1'b1;
      else if (ovr_clr)       rx_ovr <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_en && !rx_s2) begin
          rx_state    <= RX_START;
          rx_tcnt     <= '0;
          rx_dbits    <= cfg_dbits_c;
          rx_par_mode <= cfg_par_c;
          rx_word     <= '0;
          rx_par_acc  <= 1'b0;
          rx_all_zero <= 1'b1;
          rx_perr_q   <= 1'b0;
        end
        RX_START: if (tick) begin
          if (rx_tcnt == 4'(MID)) begin
            if (rx_s2) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_tcnt  <= '0;
              rx_bcnt  <= '0;
            end
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        RX_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_samp) begin
            rx_word[rx_bcnt] <= rx_s2;
            rx_par_acc       <= rx_par_acc ^ rx_s2;
            rx_all_zero      <= rx_all_zero & ~rx_s2;
            if (rx_bcnt == rx_dbits - 1'b1)
              rx_state <= (rx_par_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
            else
              rx_bcnt <= rx_bcnt + 1'b1;
          end
        end
        RX_PARITY: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_samp) begin
            rx_perr_q   <= rx_s2 ^ rx_par_acc ^ (rx_par_mode == PAR_ODD);
            rx_all_zero <= rx_all_zero & ~rx_s2;
            rx_state    <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_samp) rx_state <= rx_brk_det ? RX_BREAK : RX_IDLE;
        end
        default: if (rx_s2) rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed self-checking bench for uart_xcvr: TX waveform, loopback, RX errors, overrun, break, reset.
module tb_uart_xcvr;
  import uart_pkg::*;

  localparam int MDW = 9;
  localparam int FAW = 4;
  localparam int BIT = 16;  // clk per bit with prescale = 0

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [15:0]    prescale = '0;
  logic [3:0]     cfg_dbits = 4'd8;
  logic [1:0]     cfg_parity = 2'b00;
  logic           cfg_stop2 = 1'b0;
  logic           tx_en = 1'b0;
  logic           rx_en = 1'b0;
  logic           wr = 1'b0;
  logic [MDW-1:0] wdata = '0;
  logic           tx_empty, tx_full, tx_busy;
  logic [FAW:0]   tx_level, rx_level;
  logic           rd = 1'b0;
  logic [MDW-1:0] rdata;
  logic           rx_perr, rx_ferr, rx_empty, rx_full, rx_ovr, rx_break;
  logic           ovr_clr = 1'b0;
  logic           rx_line, tx_line;
  logic           rx_drv = 1'b1;
  logic           loop = 1'b0;

  logic [MDW+1:0] exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;

  assign rx_line = loop ? tx_line : rx_drv;

  uart_xcvr #(.MDW(MDW), .FAW(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
    .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_en(tx_en), .rx_en(rx_en), .wr(wr), .wdata(wdata),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy),
    .rd(rd), .rdata(rdata), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level),
    .rx_ovr(rx_ovr), .ovr_clr(ovr_clr), .rx_break(rx_break),
    .RX(rx_line), .TX(tx_line)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MDW+1:0] pack(input logic [MDW-1:0] d, input logic pe, input logic fe);
    return {d, pe, fe};
  endfunction

  task automatic check_head(input string tag);
    logic [MDW+1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'({rdata, rx_perr, rx_ferr}), 32'(e));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [MDW-1:0] d);
    wr    = 1'b1;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic wait_tx_idle(input int max_cyc);
    int n = 0;
    while (!(tx_empty && !tx_busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_wait", 32'(n < max_cyc), 32'd1);
  endtask

  // nbits data, optional parity bit value, stop bit value, then idle bits
  task automatic send_rx(input logic [MDW-1:0] d, input int nbits, input bit has_par,
                         input logic par_bit, input logic stop_bit, input int idle_bits);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (has_par) begin
      rx_drv = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (idle_bits * BIT) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] wave;
    int          brk_cnt;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_line), 32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_full", 32'(rx_full), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_ovr", 32'(rx_ovr), 32'd0);
    check("rst_rx_break", 32'(rx_break), 32'd0);
    check("rst_head", 32'({rdata, rx_perr, rx_ferr}), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(negedge clk);

    // TX 8E1, 0x0A5: start, 1,0,1,0,0,1,0,1, parity 0, stop
    cfg_dbits = 4'd8; cfg_parity = 2'b01; cfg_stop2 = 1'b0; tx_en = 1'b1;
    wave = 11'b1_0_10100101_0;
    push_word(9'h0A5);
    check("tx_wr_empty", 32'(tx_empty), 32'd0);
    check("tx_wr_level", 32'(tx_level), 32'd1);
    check("tx_wr_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("tx_pop_busy", 32'(tx_busy), 32'd1);
    check("tx_pop_empty", 32'(tx_empty), 32'd1);
    check("tx_pop_line", 32'(tx_line), 32'd1);
    repeat (8) @(negedge clk);
    check("tx_bit0", 32'(tx_line), 32'(wave[0]));
    for (int i = 1; i < 11; i++) begin
      repeat (BIT) @(negedge clk);
      check($sformatf("tx_bit%0d", i), 32'(tx_line), 32'(wave[i]));
    end
    repeat (7) @(negedge clk);
    check("tx_busy_176", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("tx_busy_177", 32'(tx_busy), 32'd0);
    repeat (4) @(negedge clk);

    // Loopback 5O2
    cfg_dbits = 4'd5; cfg_parity = 2'b10; cfg_stop2 = 1'b1; rx_en = 1'b1; loop = 1'b1;
    push_word(9'h000); exp_q.push_back(pack(9'h000, 1'b0, 1'b0));
    push_word(9'h01F); exp_q.push_back(pack(9'h01F, 1'b0, 1'b0));
    push_word(9'h015); exp_q.push_back(pack(9'h015, 1'b0, 1'b0));
    wait_tx_idle(2000);
    repeat (40) @(negedge clk);
    check("loop_level", 32'(rx_level), 32'd3);
    check_head("loop_w0");
    check_head("loop_w1");
    check_head("loop_w2");
    check("loop_drained", 32'(rx_empty), 32'd1);
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);

    // 9N1 with stop bit forced low -> framing error
    cfg_dbits = 4'd9; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    send_rx(9'h1A5, 9, 1'b0, 1'b0, 1'b0, 2);
    exp_q.push_back(pack(9'h1A5, 1'b0, 1'b1));
    // 8E1 0x3C (four ones, parity 0) sent with parity 1
    cfg_dbits = 4'd8; cfg_parity = 2'b01;
    send_rx(9'h03C, 8, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back(pack(9'h03C, 1'b1, 1'b0));
    check("err_level", 32'(rx_level), 32'd2);
    check_head("ferr_word");
    check_head("perr_word");

    // False start: 4-tick low glitch, then a valid 8N1 frame
    cfg_parity = 2'b00;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("fstart_level", 32'(rx_level), 32'd0);
    check("fstart_state", 32'(dut.rx_state), 32'(RX_IDLE));
    send_rx(9'h055, 8, 1'b0, 1'b0, 1'b1, 1);
    exp_q.push_back(pack(9'h055, 1'b0, 1'b0));
    check_head("post_fstart");

    // 17 frames without reading: 16 stored, one overrun
    for (int i = 0; i < 17; i++) begin
      send_rx(9'(i * 7 + 3), 8, 1'b0, 1'b0, 1'b1, 1);
      if (i < 16) exp_q.push_back(pack(9'(i * 7 + 3), 1'b0, 1'b0));
    end
    check("ovr_level", 32'(rx_level), 32'd16);
    check("ovr_full", 32'(rx_full), 32'd1);
    check("ovr_flag", 32'(rx_ovr), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(rx_ovr), 32'd0);
    for (int i = 0; i < 16; i++) check_head($sformatf("ovr_drain%0d", i));
    check("ovr_drained", 32'(rx_empty), 32'd1);

    // Break: 12 bit times low in 8N1
    brk_cnt = 0;
    rx_drv = 1'b0;
    for (int i = 0; i < 12 * BIT; i++) begin
      @(negedge clk);
      brk_cnt += int'(rx_break);
    end
    check("brk_level_low", 32'(rx_level), 32'd1);
    rx_drv = 1'b1;
    for (int i = 0; i < 3 * BIT; i++) begin
      @(negedge clk);
      brk_cnt += int'(rx_break);
    end
    check("brk_pulses", 32'(brk_cnt), 32'd1);
    check("brk_level", 32'(rx_level), 32'd1);
    exp_q.push_back(pack(9'h000, 1'b0, 1'b1));
    check_head("brk_word");

    // Asynchronous reset in the middle of a TX frame
    push_word(9'h000);
    push_word(9'h000);
    repeat (60) @(negedge clk);
    check("prerst_tx", 32'(tx_line), 32'd0);
    check("prerst_level", 32'(tx_level), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx_line), 32'd1);
    check("rst_mid_level", 32'(tx_level), 32'd0);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_empty", 32'(tx_empty), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised, frame-configurable UART transceiver, the successor to the fixed 8N1 UART. It supports 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. It adds RX false-start rejection, per-word parity/framing status, break detection and sticky overrun. It sits behind the bus-wrapper register file, which drives the config inputs and the FIFO read/write strobes.

## Interface
- `MDW`, default 9: maximum data width. It sets the `wdata`/`rdata` width.
- `FAW`, default 4: FIFO address width. Depth is 2**FAW per direction.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: baud generator enable.
- `prescale` in 16: baud tick period minus one. Baud = clk/((prescale+1)*16).
- `cfg_dbits` in 4: data bits, 5..9. Values <5 are treated as 5; values >9 are treated as 9.
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 1 = two stop bits on TX.
- `tx_en` / `rx_en` in 1: transmitter / receiver enable.
- `wr` in 1: push `wdata` into the TX FIFO. Ignored when full.
- `wdata` in MDW: TX word, LSB first. Bits at and above `cfg_dbits` are ignored.
- `tx_empty`, `tx_full` out 1; `tx_level` out FAW+1: TX FIFO status.
- `tx_busy` out 1: TX FSM not idle.
- `rd` in 1: pop the RX FIFO head. Ignored when empty.
- `rdata` out MDW: RX FIFO head (show-ahead). Unused upper bits are 0.
- `rx_perr`, `rx_ferr` out 1: parity / framing error of the head word.
- `rx_empty`, `rx_full` out 1; `rx_level` out FAW+1: RX FIFO status.
- `rx_ovr` out 1: sticky overrun.
- `ovr_clr` in 1: clears `rx_ovr`.
- `rx_break` out 1: one-cycle pulse on break detection.
- `RX` in 1: serial input, asynchronous.
- `TX` out 1: serial output.
- Reset values: `TX`=1; `tx_empty`=`rx_empty`=1; full flags, levels, `tx_busy`, `rx_ovr`, `rx_break`, `rx_perr`, `rx_ferr` = 0; `rdata`=0.

## Operation
- **Baud generator:** counter 0..`prescale`. `tick`=1 when count==`prescale`. The counter holds while `en`=0.
- **Frame config:** TX latches config on leaving IDLE. RX latches config on start detection. Changes mid-frame have no effect on the frame in progress.
- **TX FSM:** IDLE→START→DATA→PARITY (skipped if none)→STOP1→STOP2 (only if `cfg_stop2`)→IDLE.
  - Each bit lasts 16 ticks.
  - On leaving IDLE (requires `tx_en`=1 and FIFO non-empty), the FIFO is popped and the word latched.
  - Even parity is the XOR of the data bits. Odd parity is its inverse.
  - When `tx_en` drops, the current frame completes; no new frame starts.
- **RX:**
  - `RX` passes through a 2-flop synchronizer.
  - IDLE waits for `rx_en`=1 and a synced low, then moves to START and clears the tick count.
  - At START tick 7 (mid-bit): if the line is high, return to IDLE (false start, nothing pushed).
  - Data bits, parity and stop are sampled every 16 ticks after the mid-bit point.
  - Only the first stop bit is checked.
  - `perr` = parity mismatch. `ferr` = stop sampled 0.
  - Word and flags are pushed at the stop sample tick.
  - Break: all data bits, parity and stop sampled 0. The word is pushed with `ferr`=1, `rx_break` pulses, and RX waits for the line to return high before re-entering IDLE.
- **RX overrun:** a push while the RX FIFO is full drops the word and sets `rx_ovr`. If `ovr_clr` and a new overrun occur in the same cycle, set wins.
- **FIFO rules:**
  - rd&wr when empty: write only.
  - rd&wr when full: read only (the write is dropped; on RX this counts as overrun).
  - Otherwise rd&wr: both take effect, level unchanged.
  - Level reaches 2**FAW when full, with no wrap. Pointers wrap modulo depth.

## Timing
- `wr` sampled at edge N into an empty TX FIFO: `tx_empty`=0 after N; the FSM leaves IDLE and pops at N+1; `TX` (registered) goes low after N+2.
- With `prescale`=P, each bit lasts 16(P+1) clk.
- RX: `rx_empty` deasserts 1 cycle after the stop sample tick. Sampling points are delayed 2 cycles by the synchronizer.
- Asynchronous reset mid-frame: both FSMs go to IDLE, `TX`=1 immediately, FIFOs empty, partial words discarded.

## Structure
- Package `uart_pkg`:
  - parity enum (NONE/EVEN/ODD)
  - TX state enum
  - RX state enum
  - `OVS`=16
  - `MID`=7
- Sub-module `uart_fifo` #(DW, AW): used by TX with DW=MDW and by RX with DW=MDW+2 (data, perr, ferr).
- Baud generator, TX FSM and RX FSM are inline in `uart_xcvr`.

## Test plan
- P=0, 8E1, `wdata`=0x0A5 → TX waveform: 0,1,0,1,0,0,1,0,1,0(parity),1, 16 clk per bit. `tx_busy` falls after 176 clk.
- Loopback TX→RX, 5O2, words 0x00, 0x1F, 0x15 → `rdata` = same values, `perr`=`ferr`=0, `rx_level`=3.
- RX stimulus 9N1 with a corrupted stop bit → word pushed with `rx_ferr`=1. Flipped parity bit in 8E1 → `rx_perr`=1.
- RX low pulse of 4 ticks then high → no push, FSM returns to IDLE.
- 17 RX frames with no `rd` (FAW=4) → `rx_level`=16, `rx_full`=1, `rx_ovr`=1. `ovr_clr` → 0.
- RX held low 12 bit times in 8N1 → one word 0x00 with `ferr`=1, one `rx_break` pulse, no further pushes until RX goes high. Reset asserted mid-TX frame → `TX`=1 and `tx_level`=0.
